// File: rtl/bcd_conv_pkg.sv
// Shared constants, FSM state type and the add-3 nibble correction
// used by the shared binary-to-BCD converter.
package bcd_conv_pkg;

    localparam int BIN_W   = 8;   // binary operand width
    localparam int DIGIT_W = 4;   // one BCD digit
    localparam int SHREG_W = 20;  // 3 BCD digits + binary operand
    localparam int N_ITER  = 8;   // one shift per operand bit
    localparam int CNT_W   = 4;   // holds 0..N_ITER

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Double-dabble correction: a digit of 5 or more becomes 10 or more
    // after the next shift, so pre-add 3 to carry into the next digit.
    function automatic logic [DIGIT_W-1:0] add3(input logic [DIGIT_W-1:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/bcd_shift_add3_core.sv
// Sequential shift-add-3 core: one correction+shift per step,
// operand loaded into the low byte with the BCD field cleared.
module bcd_shift_add3_core
    import bcd_conv_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [BIN_W-1:0]   bin,
    input  logic               step,
    output logic               done,
    output logic [DIGIT_W-1:0] cientos,
    output logic [DIGIT_W-1:0] dieces,
    output logic [DIGIT_W-1:0] unos
);

    logic [SHREG_W-1:0] shreg_q, shreg_d;
    logic [SHREG_W-1:0] adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Next register value: load wins over step; step corrects then shifts.
    always_comb begin
        adj          = shreg_q;
        adj[19:16]   = add3(shreg_q[19:16]);
        adj[15:12]   = add3(shreg_q[15:12]);
        adj[11:8]    = add3(shreg_q[11:8]);
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        if (load) begin
            shreg_d = {{(SHREG_W-BIN_W){1'b0}}, bin};
            cnt_d   = '0;
        end else if (step) begin
            shreg_d = {adj[SHREG_W-2:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // Shift register and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // High while the step about to be taken is the last one, so the
    // controller can leave SHIFT on the same edge as the final shift.
    assign done    = (cnt_q == CNT_W'(N_ITER - 1));
    assign cientos = shreg_q[19:16];
    assign dieces  = shreg_q[15:12];
    assign unos    = shreg_q[11:8];

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin front end sharing one binary-to-BCD core among NUM_REQ
// requesters; one conversion in flight, result tagged with winner id.
module bcd_convert_arbiter
    import bcd_conv_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*BIN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [DIGIT_W-1:0]       rsp_cientos,
    output logic [DIGIT_W-1:0]       rsp_dieces,
    output logic [DIGIT_W-1:0]       rsp_unos
);

    state_e               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 busy_q, busy_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [DIGIT_W-1:0]   cien_q, cien_d, diez_q, diez_d, uno_q, uno_d;

    logic                 win_found;
    logic [ID_W-1:0]      win_id;
    logic [NUM_REQ-1:0]   win_oh;
    logic [BIN_W-1:0]     win_data;

    logic                 core_load, core_step, core_done;
    logic [DIGIT_W-1:0]   core_cien, core_diez, core_uno;

    // Round-robin search upward from the requester after the last winner.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        win_oh    = '0;
        win_data  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!win_found && req[idx]) begin
                win_found   = 1'b1;
                win_id      = ID_W'(idx);
                win_oh[idx] = 1'b1;
                win_data    = req_data[idx*BIN_W +: BIN_W];
            end
        end
    end

    // Controller: grant and load in IDLE, step the core, publish in DONE.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_id_d    = rsp_id_q;
        cien_d      = cien_q;
        diez_d      = diez_q;
        uno_d       = uno_q;
        core_load   = 1'b0;
        core_step   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    core_load = 1'b1;
                    ptr_d     = win_id;
                    id_d      = win_id;
                    gnt_d     = win_oh;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                core_step = 1'b1;
                if (core_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                cien_d      = core_cien;
                diez_d      = core_diez;
                uno_d       = core_uno;
                rsp_id_d    = id_q;
                rsp_valid_d = NUM_REQ'(1) << id_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Control and response registers; reset aborts any conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_id_q    <= '0;
            cien_q      <= '0;
            diez_q      <= '0;
            uno_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            cien_q      <= cien_d;
            diez_q      <= diez_d;
            uno_q       <= uno_d;
        end
    end

    bcd_shift_add3_core u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (core_load),
        .bin     (win_data),
        .step    (core_step),
        .done    (core_done),
        .cientos (core_cien),
        .dieces  (core_diez),
        .unos    (core_uno)
    );

    assign gnt         = gnt_q;
    assign busy        = busy_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_cientos = cien_q;
    assign rsp_dieces  = diez_q;
    assign rsp_unos    = uno_q;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Directed bench for bcd_convert_arbiter with three requesters.
module tb_bcd_convert_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ID_W    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0;
    logic [23:0] req_data = '0;
    logic [2:0]  gnt;
    logic        busy;
    logic [2:0]  rsp_valid;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_cientos, rsp_dieces, rsp_unos;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_convert_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .busy        (busy),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_cientos (rsp_cientos),
        .rsp_dieces  (rsp_dieces),
        .rsp_unos    (rsp_unos)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_digits(input string tag, input int c, input int d, input int u);
        chk({tag, "_c"}, 32'(rsp_cientos), 32'(c));
        chk({tag, "_d"}, 32'(rsp_dieces), 32'(d));
        chk({tag, "_u"}, 32'(rsp_unos), 32'(u));
    endtask

    // From the cycle after the grant edge: 8 busy cycles, then the response.
    task automatic finish_conv(input int idx, input int c, input int d, input int u);
        logic ok;
        ok = 1'b1;
        repeat (8) begin
            tick();
            if (!(busy === 1'b1 && rsp_valid === 3'b000 && gnt === 3'b000)) ok = 1'b0;
        end
        chk("busy_mid", 32'(ok), 32'd1);
        tick();
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << idx);
        chk("rsp_id", 32'(rsp_id), 32'(idx));
        chk_digits("digits", c, d, u);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    int bvals [7] = '{0, 9, 10, 99, 100, 199, 200};
    int bc    [7] = '{0, 0, 0, 0, 1, 1, 2};
    int bd    [7] = '{0, 0, 1, 9, 0, 9, 0};
    int bu    [7] = '{0, 9, 0, 9, 0, 9, 0};

    initial begin
        logic ok;

        // Reset state
        #2;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk_digits("rst_digits", 0, 0, 0);
        #20;
        rst_n = 1'b1;
        tick();

        // Single requester 1 with 255
        req[1] = 1'b1;
        req_data[15:8] = 8'd255;
        tick();
        chk("t1_gnt", 32'(gnt), 32'b010);
        chk("t1_busy", 32'(busy), 1);
        req[1] = 1'b0;
        finish_conv(1, 2, 5, 5);
        tick();
        chk("t1_rsp_drop", 32'(rsp_valid), 0);
        chk_digits("t1_hold", 2, 5, 5);

        // Boundary operands on requester 0 (pointer at 1, so 0 wins)
        for (int k = 0; k < 7; k++) begin
            req[0] = 1'b1;
            req_data[7:0] = 8'(bvals[k]);
            tick();
            chk("bnd_gnt", 32'(gnt), 32'b001);
            req[0] = 1'b0;
            finish_conv(0, bc[k], bd[k], bu[k]);
        end

        // Fresh reset puts the pointer back so requester 0 goes first
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();

        // All three held high: grants 0,1,2,0 back to back
        req = 3'b111;
        req_data = {8'd56, 8'd34, 8'd12};
        tick();
        chk("rr_gnt0", 32'(gnt), 32'b001);
        finish_conv(0, 0, 1, 2);
        tick();
        chk("rr_gnt1", 32'(gnt), 32'b010);
        chk("rr_busy1", 32'(busy), 1);
        finish_conv(1, 0, 3, 4);
        tick();
        chk("rr_gnt2", 32'(gnt), 32'b100);
        finish_conv(2, 0, 5, 6);
        tick();
        chk("rr_gnt0b", 32'(gnt), 32'b001);
        req = 3'b000;
        finish_conv(0, 0, 1, 2);

        // Requester 2 arrives mid-conversion; wins over 0 once pointer=1
        req[1] = 1'b1;
        req_data[15:8] = 8'd128;
        tick();
        chk("late_gnt1", 32'(gnt), 32'b010);
        req[1] = 1'b0;
        tick(); tick(); tick();
        req[2] = 1'b1;
        req[0] = 1'b1;
        req_data[23:16] = 8'd73;
        req_data[7:0]   = 8'd41;
        ok = 1'b1;
        repeat (5) begin
            tick();
            if (gnt !== 3'b000) ok = 1'b0;
        end
        chk("late_no_gnt", 32'(ok), 1);
        tick();
        chk("late_rsp1", 32'(rsp_valid), 32'b010);
        chk_digits("late_dig1", 1, 2, 8);
        tick();
        chk("late_gnt2", 32'(gnt), 32'b100);
        req = 3'b000;
        finish_conv(2, 0, 7, 3);

        // Short req pulse on 1 while busy is forgotten
        req[0] = 1'b1;
        req_data[7:0] = 8'd47;
        tick();
        chk("pulse_gnt0", 32'(gnt), 32'b001);
        req[0] = 1'b0;
        tick(); tick();
        req[1] = 1'b1;
        req_data[15:8] = 8'd99;
        tick();
        req[1] = 1'b0;
        repeat (5) tick();
        tick();
        chk("pulse_rsp0", 32'(rsp_valid), 32'b001);
        chk_digits("pulse_dig", 0, 4, 7);
        ok = 1'b1;
        repeat (12) begin
            tick();
            if (gnt !== 3'b000 || rsp_valid !== 3'b000 || busy !== 1'b0 ||
                rsp_cientos !== 4'd0 || rsp_dieces !== 4'd4 || rsp_unos !== 4'd7)
                ok = 1'b0;
        end
        chk("pulse_quiet", 32'(ok), 1);

        // Reset at counter=4 aborts the conversion
        req[1] = 1'b1;
        req_data[15:8] = 8'd250;
        tick();
        chk("abort_gnt1", 32'(gnt), 32'b010);
        req[1] = 1'b0;
        repeat (4) tick();
        chk("abort_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_gnt", 32'(gnt), 0);
        chk("abort_rsp_valid", 32'(rsp_valid), 0);
        chk("abort_rsp_id", 32'(rsp_id), 0);
        chk_digits("abort_digits", 0, 0, 0);
        #2;
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (12) begin
            tick();
            if (rsp_valid !== 3'b000 || gnt !== 3'b000 || busy !== 1'b0) ok = 1'b0;
        end
        chk("abort_no_rsp", 32'(ok), 1);
        req = 3'b011;
        req_data[7:0]  = 8'd5;
        req_data[15:8] = 8'd6;
        tick();
        chk("abort_first0", 32'(gnt), 32'b001);
        req = 3'b000;
        finish_conv(0, 0, 0, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
